// File: rtl/if_id_reg_pkg.sv
// IF/ID shared constants, exception codes and pipeline bundle.
// Address map follows the instruction memory window 0x3000..0x6FFC.
package if_id_reg_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_TOP    = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc_code;
    logic        bd;
    logic        valid;
  } if_id_t;

  function automatic if_id_t bubble(
    input logic [31:0] pc
  );
    if_id_t b;
    b.pc       = pc;
    b.instr    = NOP;
    b.exc_code = EXC_NONE;
    b.bd       = 1'b0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg_fetch_exc_check.sv
// Fetch address check: misaligned or outside the
// instruction memory window raises AdEL.
module fetch_exc_check
  import if_id_reg_pkg::*;
(
  input  logic [31:0] pc,
  output logic        adel
);

  logic misaligned;
  logic below;
  logic above;

  assign misaligned = pc[1:0] != 2'b00;
  assign below      = pc < IM_BASE;
  assign above      = pc > IM_TOP;
  assign adel       = misaligned | below | above;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush, exception
// redirect and fetch address exception capture.
module if_id_reg
  import if_id_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        en,
  input  logic        eret_flush,
  input  logic        d_is_branch,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exc_code,
  output logic        d_bd,
  output logic        d_valid
);

  if_id_t q;
  if_id_t ld;
  logic   adel;

  fetch_exc_check u_chk (
    .pc   (f_pc),
    .adel (adel)
  );

  // a faulting fetch keeps its PC but carries a nop
  always_comb begin
    ld.pc       = f_pc;
    ld.instr    = adel ? NOP : f_instr;
    ld.exc_code = adel ? EXC_ADEL : EXC_NONE;
    ld.bd       = d_is_branch;
    ld.valid    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= bubble(PC_RESET);
    end else if (req) begin
      q <= bubble(EXC_ENTRY);
    end else if (!en) begin
      q <= q;
    end else if (eret_flush) begin
      q <= bubble(f_pc);
    end else begin
      q <= ld;
    end
  end

  assign d_pc       = q.pc;
  assign d_instr    = q.instr;
  assign d_exc_code = q.exc_code;
  assign d_bd       = q.bd;
  assign d_valid    = q.valid;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for the IF/ID register.
// Expected values are hand computed per step.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        en;
  logic        eret_flush;
  logic        d_is_branch;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic [4:0]  d_exc_code;
  logic        d_bd;
  logic        d_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  if_id_reg dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .en          (en),
    .eret_flush  (eret_flush),
    .d_is_branch (d_is_branch),
    .f_pc        (f_pc),
    .f_instr     (f_instr),
    .d_pc        (d_pc),
    .d_instr     (d_instr),
    .d_exc_code  (d_exc_code),
    .d_bd        (d_bd),
    .d_valid     (d_valid)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(
    input string       tag,
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic [4:0]  exc,
    input logic        bd,
    input logic        valid
  );
    chk({tag, ".pc"}, d_pc, pc);
    chk({tag, ".instr"}, d_instr, instr);
    chk({tag, ".exc"}, 32'(d_exc_code), 32'(exc));
    chk({tag, ".bd"}, 32'(d_bd), 32'(bd));
    chk({tag, ".valid"}, 32'(d_valid), 32'(valid));
  endtask

  initial begin
    reset = 1'b1;
    req = 1'b0;
    en = 1'b0;
    eret_flush = 1'b0;
    d_is_branch = 1'b0;
    f_pc = 32'h0;
    f_instr = 32'h0;
    step();
    chk_all("reset", 32'h3000, 0, 0, 0, 0);

    // normal load, delay slot flagged
    reset = 1'b0;
    en = 1'b1;
    f_pc = 32'h3004;
    f_instr = 32'h2408_0001;
    d_is_branch = 1'b1;
    #1;
    chk("no_comb_path", d_pc, 32'h3000);
    step();
    chk_all("load", 32'h3004, 32'h2408_0001, 0, 1, 1);

    d_is_branch = 1'b0;
    f_instr = 32'hFFFF_FFFF;
    f_pc = 32'h3002;
    step();
    chk_all("adel_3002", 32'h3002, 0, 4, 0, 1);
    f_pc = 32'h7000;
    step();
    chk_all("adel_7000", 32'h7000, 0, 4, 0, 1);

    f_instr = 32'h1234_5678;
    f_pc = 32'h3000;
    step();
    chk_all("ok_3000", 32'h3000, 32'h1234_5678, 0, 0, 1);
    f_pc = 32'h6FFC;
    step();
    chk_all("ok_6ffc", 32'h6FFC, 32'h1234_5678, 0, 0, 1);
    f_pc = 32'h2FFC;
    step();
    chk_all("adel_2ffc", 32'h2FFC, 0, 4, 0, 1);
    f_pc = 32'hFFFF_FFFC;
    step();
    chk_all("adel_top", 32'hFFFF_FFFC, 0, 4, 0, 1);

    // stall holds contents, including the bd flag
    f_pc = 32'h3008;
    f_instr = 32'h1111_1111;
    d_is_branch = 1'b1;
    step();
    chk_all("ld_3008", 32'h3008, 32'h1111_1111, 0, 1, 1);
    en = 1'b0;
    eret_flush = 1'b1;
    d_is_branch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f_pc = 32'h3100 + 32'(i * 4);
      f_instr = 32'hA5A5_0000 + 32'(i);
      step();
      chk_all("stall", 32'h3008, 32'h1111_1111, 0, 1, 1);
    end

    // req beats stall and flush
    req = 1'b1;
    step();
    chk_all("req", 32'h4180, 0, 0, 0, 0);
    req = 1'b0;
    en = 1'b1;
    f_pc = 32'h4184;
    f_instr = 32'h2222_2222;
    d_is_branch = 1'b1;
    step();
    chk_all("eret", 32'h4184, 0, 0, 0, 0);

    // req with en=1 still redirects
    eret_flush = 1'b0;
    req = 1'b1;
    step();
    chk_all("req_en", 32'h4180, 0, 0, 0, 0);
    req = 1'b0;

    reset = 1'b1;
    req = 1'b1;
    eret_flush = 1'b1;
    step();
    chk_all("rst_req", 32'h3000, 0, 0, 0, 0);

    // reset during a stall clears held contents
    reset = 1'b0;
    req = 1'b0;
    eret_flush = 1'b0;
    en = 1'b1;
    f_pc = 32'h300C;
    f_instr = 32'h3333_3333;
    step();
    chk_all("ld_300c", 32'h300C, 32'h3333_3333, 0, 1, 1);
    en = 1'b0;
    reset = 1'b1;
    step();
    chk_all("rst_stall", 32'h3000, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on posedge clk only.
REQ-002 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-003 req  input  1  exception/interrupt request from CP0; redirect pipeline to handler.
REQ-004 en  input  1  stage enable; 0 = stall (hold contents).
REQ-005 eret_flush  input  1  D-stage eret detected; instruction fetched behind it is discarded.
REQ-006 d_is_branch  input  1  instruction currently in D is branch/jump; incoming F instruction is its delay slot.
REQ-007 f_pc  input  32  PC of instruction being fetched.
REQ-008 f_instr  input  32  instruction word read from IM at f_pc.
REQ-009 d_pc  output  32  registered PC of D-stage instruction.
REQ-010 d_instr  output  32  registered D-stage instruction word.
REQ-011 d_exc_code  output  5  registered fetch exception code (0 none, 4 AdEL).
REQ-012 d_bd  output  1  registered branch-delay-slot flag.
REQ-013 d_valid  output  1  1 = real instruction, 0 = bubble.

Function
REQ-014 Update priority per edge SHALL be: reset > req > hold (en=0) > eret_flush > load.
REQ-015 req=1: d_pc <= 0x0000_4180, d_instr <= 0, d_exc_code <= 0, d_bd <= 0, d_valid <= 0, regardless of en and eret_flush.
REQ-016 en=0 (no reset/req): all outputs hold previous values; eret_flush ignored that cycle.
REQ-017 en=1, eret_flush=1: bubble loaded -- d_pc <= f_pc, d_instr <= 0, d_exc_code <= 0, d_bd <= 0, d_valid <= 0.
REQ-018 en=1, load: d_pc <= f_pc, d_bd <= d_is_branch, d_valid <= 1, d_exc_code/d_instr per REQ-019..021.
REQ-019 Fetch AdEL SHALL be flagged when f_pc[1:0] != 0, or f_pc < 0x0000_3000, or f_pc > 0x0000_6FFC (unsigned 32-bit compares).
REQ-020 On AdEL: d_exc_code <= 4, d_instr <= 0 (nop), d_pc <= faulting f_pc unmodified.
REQ-021 No AdEL: d_exc_code <= 0, d_instr <= f_instr.
REQ-022 Boundaries: f_pc=0x3000 and 0x6FFC legal; 0x2FFC, 0x7000, 0x3002 AdEL; 0xFFFF_FFFC AdEL with no wrap artefact.
REQ-023 Latency: exactly one cycle from F inputs to D outputs; no combinational path input->output.
REQ-024 d_bd SHALL be captured from d_is_branch sampled on the same edge, so a held (stalled) delay slot keeps its flag.

Reset
REQ-025 reset=1 at posedge: d_pc <= 0x0000_3000, d_instr <= 0, d_exc_code <= 0, d_bd <= 0, d_valid <= 0.
REQ-026 reset overrides req, en, eret_flush simultaneously asserted; mid-stall reset clears held contents.

Structure
REQ-027 Shared package SHALL hold PC_RESET (0x3000), EXC_ENTRY (0x4180), IM_BASE (0x3000), IM_TOP (0x6FFC), EXC_NONE (0), EXC_ADEL (4), NOP (0).
REQ-028 Sub-module fetch_exc_check (combinational: f_pc -> adel) SHALL implement REQ-019 and be reused by other address checks.
REQ-029 Single always block for the register; no latches, no async logic.

Verification
REQ-030 reset 1 cycle -> d_pc=0x3000, d_instr=0, d_valid=0, d_bd=0, d_exc_code=0.
REQ-031 en=1, f_pc=0x3004, f_instr=0x2408_0001, d_is_branch=1 -> next cycle d_pc=0x3004, d_instr=0x2408_0001, d_bd=1, d_valid=1, d_exc_code=0.
REQ-032 f_pc=0x3002 then 0x7000, f_instr=0xFFFF_FFFF -> d_exc_code=4, d_instr=0, d_pc=faulting PC, d_valid=1.
REQ-033 load 0x3008, then en=0 for 3 cycles with changing f_pc/f_instr and eret_flush=1 -> outputs stay at 0x3008 contents.
REQ-034 en=0, eret_flush=1, req=1 same edge -> d_pc=0x4180, d_instr=0, d_valid=0; next cycle en=1, eret_flush=1, f_pc=0x4184 -> d_pc=0x4184, d_valid=0.
REQ-035 reset=1 and req=1 same edge -> d_pc=0x3000 (reset wins).
